// File: rtl/wch_scheduler.sv
// ============================================================================
//  Module   : wch_scheduler
//  Purpose  : Walks the neurons flagged for an STDP update in ascending order.
//             For each one it starts weight_change, sweeps every input and
//             waits for completion, with a bounded wait.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module wch_scheduler #(
    parameter int N   = 8,
    parameter int N1  = 784,
    parameter int SW  = 3,
    parameter int TMO = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    input  logic [N-1:0]  req_mask,
    input  logic [N-1:0]  req_sign,
    output logic          req_ready,
    output logic [SW-1:0] neuron_sel,
    output logic          start_wch,
    output logic          spike_hold,
    output logic [9:0]    ip_select,
    input  logic          valid_wch,
    output logic          wch_busy,
    output logic          done,
    output logic          err,
    input  logic          err_clr
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PICK  = 3'd1,
        S_START = 3'd2,
        S_SWEEP = 3'd3,
        S_DRAIN = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam int              c_CW       = $clog2(TMO + 1);
    localparam logic [9:0]      c_IP_LAST  = 10'(N1 - 1);
    localparam logic [c_CW-1:0] c_TMO_LAST = c_CW'(TMO - 1);
    localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);

    state_t          r_state;
    logic [N-1:0]    r_pending;
    logic [N-1:0]    r_sign;
    logic [c_CW-1:0] r_tmo_cnt;
    logic [SW-1:0]   w_low_idx;
    logic            w_timeout;

    // Lowest set bit wins: scanning from the top lets the last hit stand.
    always_comb begin
        w_low_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_low_idx = SW'(i);
            end
        end
    end

    assign w_timeout = (r_state == S_DRAIN) && !valid_wch && (r_tmo_cnt == c_TMO_LAST);
    assign req_ready = (r_state == S_IDLE);
    assign wch_busy  = (r_state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_pending  <= '0;
            r_sign     <= '0;
            r_tmo_cnt  <= '0;
            neuron_sel <= '0;
            start_wch  <= 1'b0;
            spike_hold <= 1'b0;
            ip_select  <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            start_wch <= 1'b0;
            done      <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_pending <= req_mask;
                        r_sign    <= req_sign;
                        r_state   <= S_PICK;
                    end
                end
                S_PICK: begin
                    if (r_pending == '0) begin
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        neuron_sel <= w_low_idx;
                        spike_hold <= r_sign[w_low_idx];
                        start_wch  <= 1'b1;
                        r_state    <= S_START;
                    end
                end
                S_START: begin
                    ip_select <= 10'd1;
                    r_state   <= S_SWEEP;
                end
                S_SWEEP: begin
                    if (ip_select == c_IP_LAST) begin
                        r_tmo_cnt <= '0;
                        r_state   <= S_DRAIN;
                    end else begin
                        ip_select <= ip_select + 10'd1;
                    end
                end
                S_DRAIN: begin
                    // A timed-out neuron is dropped just like a completed one.
                    if (valid_wch || w_timeout) begin
                        r_pending[neuron_sel] <= 1'b0;
                        ip_select             <= '0;
                        r_state               <= S_PICK;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + c_CNT_ONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            if (w_timeout) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_wch_scheduler.sv
// ============================================================================
//  Module   : tb_wch_scheduler
//  Purpose  : Self-checking bench for wch_scheduler; expected per-cycle
//             outputs are laid out as a timeline built from the round rules.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_wch_scheduler;

    localparam int N   = 8;
    localparam int N1  = 784;
    localparam int SW  = 3;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_valid = 1'b0;
    logic [N-1:0]  req_mask = '0;
    logic [N-1:0]  req_sign = '0;
    logic          req_ready;
    logic [SW-1:0] neuron_sel;
    logic          start_wch;
    logic          spike_hold;
    logic [9:0]    ip_select;
    logic          valid_wch = 1'b0;
    logic          wch_busy;
    logic          done;
    logic          err;
    logic          err_clr = 1'b0;

    always #5 clk = ~clk;

    wch_scheduler #(.N(N), .N1(N1), .SW(SW), .TMO(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_mask   (req_mask),
        .req_sign   (req_sign),
        .req_ready  (req_ready),
        .neuron_sel (neuron_sel),
        .start_wch  (start_wch),
        .spike_hold (spike_hold),
        .ip_select  (ip_select),
        .valid_wch  (valid_wch),
        .wch_busy   (wch_busy),
        .done       (done),
        .err        (err),
        .err_clr    (err_clr)
    );

    // One cycle of the timeline: expected outputs plus the inputs driven in it.
    typedef struct packed {
        bit          ready;
        bit          busy;
        bit          start;
        bit          hold;
        bit          dn;
        bit          err;
        bit [SW-1:0] sel;
        bit [9:0]    ip;
        bit          drv_valid;
        bit          drv_clr;
        bit          drv_req;
        bit [N-1:0]  drv_mask;
        bit [N-1:0]  drv_sign;
    } ent_t;

    int          n_cmp = 0;
    int          n_fail = 0;
    bit [SW-1:0] m_sel = '0;
    bit          m_hold = 1'b0;
    bit          m_err = 1'b0;
    bit          noise_on = 1'b0;
    ent_t        e0;

    task automatic chk(input string ph, input string tag, input int idx,
                       input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s/%s cyc%0d observed=%0h expected=%0h", ph, tag, idx, obs, exp);
        end
    endtask

    task automatic chk_outs(input string ph, input int idx, input ent_t e);
        chk(ph, "req_ready",  idx, 32'(req_ready),  32'(e.ready));
        chk(ph, "wch_busy",   idx, 32'(wch_busy),   32'(e.busy));
        chk(ph, "start_wch",  idx, 32'(start_wch),  32'(e.start));
        chk(ph, "spike_hold", idx, 32'(spike_hold), 32'(e.hold));
        chk(ph, "done",       idx, 32'(done),       32'(e.dn));
        chk(ph, "err",        idx, 32'(err),        32'(e.err));
        chk(ph, "neuron_sel", idx, 32'(neuron_sel), 32'(e.sel));
        chk(ph, "ip_select",  idx, 32'(ip_select),  32'(e.ip));
    endtask

    task automatic drive(input ent_t e);
        req_valid = e.drv_req;
        req_mask  = e.drv_mask;
        req_sign  = e.drv_sign;
        valid_wch = e.drv_valid;
        err_clr   = e.drv_clr;
    endtask

    // Builds one cycle of expectation from the current model state; with noise
    // on it also adds stray valid_wch, err_clr and ignored requests.
    function automatic ent_t mk(bit busy, bit start, bit dn, bit [9:0] ip, bit in_drain);
        ent_t e = '0;
        e.ready = !busy;
        e.busy  = busy;
        e.start = start;
        e.dn    = dn;
        e.ip    = ip;
        e.sel   = m_sel;
        e.hold  = m_hold;
        e.err   = m_err;
        if (noise_on) begin
            e.drv_valid = !in_drain && ($urandom_range(0, 7) == 0);
            e.drv_clr   = ($urandom_range(0, 15) == 0);
            e.drv_req   = busy && ($urandom_range(0, 15) == 0);
            e.drv_mask  = N'($urandom);
            e.drv_sign  = N'($urandom);
        end
        if (e.drv_clr) m_err = 1'b0;
        return e;
    endfunction

    // fixed_d: DRAIN cycle index at which valid_wch is returned (-1 = random).
    // stop_ip: assert rst when this ip_select is on the bus (-1 = never).
    task automatic run_round(input string ph, input bit [N-1:0] mask, input bit [N-1:0] sign,
                             input bit [N-1:0] tmo_mask, input int fixed_d,
                             input int stop_ip, input bit noise);
        ent_t q[$];
        ent_t e;
        int   d;
        @(posedge clk); #1;
        noise_on = 1'b0;
        e = mk(1'b0, 1'b0, 1'b0, 10'd0, 1'b0);
        chk_outs({ph, "_idle"}, -1, e);
        req_valid = 1'b1;
        req_mask  = mask;
        req_sign  = sign;
        valid_wch = 1'b0;
        err_clr   = 1'b0;

        noise_on = noise;
        q.push_back(mk(1'b1, 1'b0, 1'b0, 10'd0, 1'b0));
        for (int n = 0; n < N; n++) begin
            if (mask[n]) begin
                m_sel  = SW'(n);
                m_hold = sign[n];
                q.push_back(mk(1'b1, 1'b1, 1'b0, 10'd0, 1'b0));
                for (int i = 1; i < N1; i++) q.push_back(mk(1'b1, 1'b0, 1'b0, 10'(i), 1'b0));
                if (tmo_mask[n]) begin
                    for (int j = 0; j < TMO; j++) begin
                        e = mk(1'b1, 1'b0, 1'b0, 10'(N1 - 1), 1'b1);
                        if (j == TMO - 1) e.drv_clr = 1'b1;  // clear collides with timeout
                        q.push_back(e);
                    end
                    m_err = 1'b1;
                end else begin
                    d = (fixed_d >= 0) ? fixed_d : int'($urandom_range(0, TMO - 1));
                    for (int j = 0; j <= d; j++) begin
                        e = mk(1'b1, 1'b0, 1'b0, 10'(N1 - 1), 1'b1);
                        e.drv_valid = (j == d);
                        q.push_back(e);
                    end
                end
                q.push_back(mk(1'b1, 1'b0, 1'b0, 10'd0, 1'b0));
            end
        end
        q.push_back(mk(1'b1, 1'b0, 1'b1, 10'd0, 1'b0));
        q.push_back(mk(1'b0, 1'b0, 1'b0, 10'd0, 1'b0));

        for (int k = 0; k < q.size(); k++) begin
            @(posedge clk); #1;
            drive(q[k]);
            chk_outs(ph, k, q[k]);
            if (stop_ip >= 0 && q[k].busy && q[k].ip == 10'(stop_ip)) begin
                #2 rst = 1'b1;
                #1;
                e = '0;
                e.ready = 1'b1;
                chk_outs({ph, "_async_rst"}, k, e);
                req_valid = 1'b0;
                valid_wch = 1'b0;
                err_clr   = 1'b0;
                m_sel  = '0;
                m_hold = 1'b0;
                m_err  = 1'b0;
                @(posedge clk); #2 rst = 1'b0;
                return;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired compared=%0d mismatched=%0d", n_cmp, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst = 1'b1;
        #2;
        e0 = '0;
        e0.ready = 1'b1;
        chk_outs("reset", 0, e0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        run_round("single", 8'h04, 8'h04, 8'h00, 4, -1, 1'b0);
        run_round("three", 8'h91, 8'h10, 8'h00, -1, -1, 1'b0);
        run_round("empty", 8'h00, 8'h00, 8'h00, -1, -1, 1'b0);
        run_round("timeout", 8'h03, N'($urandom), 8'h01, -1, -1, 1'b0);

        // err is sticky until err_clr
        repeat (3) begin
            @(posedge clk); #1;
            chk("err_hold", "err", 0, 32'(err), 32'(m_err));
        end
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        m_err = 1'b0;
        chk("err_clr", "err", 0, 32'(err), 32'(m_err));

        run_round("noise", 8'h28 | N'($urandom), N'($urandom), 8'h00, -1, -1, 1'b1);
        run_round("abort", 8'h0F, N'($urandom), 8'h00, -1, 300, 1'b0);
        run_round("after_rst", 8'h42, 8'hC3, 8'h00, TMO - 1, -1, 1'b0);

        for (int r = 0; r < 3; r++) begin
            run_round("random", N'($urandom), N'($urandom),
                      N'($urandom) & N'($urandom) & N'($urandom), -1, -1, 1'b1);
        end

        @(posedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/wch_scheduler.md
Name: wch_scheduler

Overview:
- Sequences the per-neuron weight-change datapath (`weight_change`) across the N output neurons of a layer after each learning timestep.
- Accepts a round request: a mask of neurons whose synapse column needs an STDP update, plus a per-neuron increase/decrease sign.
- Visits the flagged neurons one at a time in ascending index order. For each one it pulses `start_wch`, sweeps `ip_select` over all N1 inputs and waits for `valid_wch`.
- Flags a busy window so the layer controller keeps inference traffic off the weight RAMs, and reports round completion and timeout errors.

Parameters:
- N, 8, number of output neurons (width of the mask and sign vectors).
- N1, 784, number of inputs per neuron; the sweep length.
- SW, 3, width of `neuron_sel`; equals clog2(N).
- TMO, 16, maximum cycles to wait in DRAIN for `valid_wch` before declaring an error.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- req_valid  in  1  round request; accepted when `req_ready`=1
- req_mask  in  N  bit i=1: neuron i needs a weight update this round
- req_sign  in  N  bit i drives `spike_hold` for neuron i (1=increase, 0=decrease)
- req_ready  out  1  scheduler idle, can accept a request
- neuron_sel  out  SW  index of the neuron whose weight bank is being updated
- start_wch  out  1  one-cycle start pulse to `weight_change`
- spike_hold  out  1  direction for the current neuron
- ip_select  out  10  input index presented to `weight_change`
- valid_wch  in  1  completion pulse from `weight_change`
- wch_busy  out  1  round in progress; inference must not access the weight RAMs
- done  out  1  one-cycle pulse at the end of a round
- err  out  1  sticky timeout flag
- err_clr  in  1  clears `err`

Behaviour:
- Reset: `rst` is asynchronous, active-high; clock is `clk`, all state on its rising edge.
- Reset values: state=IDLE, pending=0, sign register=0, `neuron_sel`=0, `start_wch`=0, `spike_hold`=0, `ip_select`=0, `done`=0, `err`=0, timeout counter=0. Hence `req_ready`=1 and `wch_busy`=0.
- `req_ready` = (state==IDLE). `wch_busy` = (state!=IDLE). Both are decoded from registered state.
- States: IDLE, PICK, START, SWEEP, DRAIN, DONE.
- IDLE: on `req_valid`, latch pending<=`req_mask` and sign<=`req_sign`, then go to PICK. `req_valid` in any other state is ignored and not queued.
- PICK:
  - If pending==0, go to DONE.
  - Otherwise `neuron_sel` <= index of the lowest set bit of pending, `spike_hold` <= sign[that index], go to START.
- START: `start_wch`=1 for exactly this cycle, `ip_select`=0. Next state is SWEEP.
- SWEEP:
  - `ip_select` increments by 1 each cycle, 1..N1-1, with no gaps.
  - After the cycle presenting N1-1, go to DRAIN and reset the timeout counter.
- DRAIN:
  - `ip_select` holds at N1-1; `start_wch`=0.
  - On `valid_wch`: clear pending[`neuron_sel`], set `ip_select`=0, go to PICK.
  - Otherwise the counter increments. When it reaches TMO: set `err`, clear pending[`neuron_sel`], set `ip_select`=0, go to PICK.
- DONE: `done`=1 for one cycle, then IDLE.
- `neuron_sel` and `spike_hold` stay constant from PICK through DRAIN of the same neuron.
- `valid_wch` outside DRAIN is ignored.
- `err_clr` clears `err`. If `err_clr` and a timeout occur in the same cycle, set wins.
- Latency, nominal path, single neuron, accept at cycle T:
  - T+1: PICK.
  - T+2: START (`ip_select`=0).
  - T+3..T+N1+1: SWEEP (`ip_select`=1..N1-1).
  - T+N1+2: DRAIN starts.
  - `valid_wch` sampled at cycle V gives PICK at V+1, `done` at V+2, `req_ready`=1 at V+3.
- Mask of 0: `done` pulses at T+2 and `start_wch` is never asserted.
- `rst` mid-round aborts immediately to reset values; the pending request is lost.

Test Plan:
1. `req_mask`=0x04, `req_sign`=0x04, bench model returns `valid_wch` 5 cycles after `ip_select`=783 -> `neuron_sel`=2, `spike_hold`=1, single `start_wch` at T+2, `ip_select` 0..783 consecutive, `done` 2 cycles after `valid_wch`, `err`=0.
2. `req_mask`=0x91, `req_sign`=0x10 -> neurons visited in order 0, 4, 7 with `spike_hold` 0, 1, 0; three `start_wch` pulses; `wch_busy` high continuously until `done`.
3. `req_mask`=0x00 -> `done` at T+2, no `start_wch`, `ip_select` stays 0, `wch_busy` high for T+1..T+2 only.
4. `req_mask`=0x03, model never asserts `valid_wch` for neuron 0 -> `err` set after 16 DRAIN cycles, neuron 1 still processed, `done` pulses; `err` stays 1 until `err_clr`.
5. `req_valid` pulsed during SWEEP with a different mask -> ignored, round unchanged, `req_ready`=0 throughout.
6. `rst` asserted while `ip_select`=300 -> outputs immediately at reset values, `req_ready`=1; a new request afterwards runs normally.
